// File: rtl/ddr3_pll_phase_stepper.sv
// Sequencer for the DDR3 PLL dynamic phase-shift port: turns an N-step request
// into N phase_step/phase_done handshakes and tracks the phase position modulo one rotation.
module ddr3_pll_phase_stepper #(
  parameter int unsigned STEP_HOLD_CYCLES    = 2,
  parameter int unsigned DONE_TIMEOUT        = 255,
  parameter int unsigned PHASE_STEPS_PER_REV = 32,
  parameter int unsigned CNT_W               = 8,
  parameter int unsigned POS_W               = $clog2(PHASE_STEPS_PER_REV)
) (
  input  logic             CLK_IN,
  input  logic             RST_IN_N,
  input  logic             PLL_LOCKED,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_updn,
  input  logic [CNT_W-1:0] req_count,
  output logic             phase_step,
  output logic             phase_updn,
  input  logic             phase_done,
  output logic             busy,
  output logic             done_pulse,
  output logic             timeout_err,
  output logic [POS_W-1:0] phase_pos
);

  localparam int unsigned HOLD_W = (STEP_HOLD_CYCLES > 1) ? $clog2(STEP_HOLD_CYCLES) : 1;
  localparam int unsigned TMO_W  = $clog2(DONE_TIMEOUT + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STEP_HOLD_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(DONE_TIMEOUT - 1);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(PHASE_STEPS_PER_REV - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic              updn_q, updn_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              seen_low_q, seen_low_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              step_q, step_d;
  logic              accept;
  logic [POS_W-1:0]  pos_next;

  assign req_ready = (state_q == S_IDLE) & PLL_LOCKED;
  assign accept    = req_valid & req_ready;
  assign pos_next  = updn_q ? ((pos_q == POS_LAST) ? '0 : pos_q + 1'b1)
                            : ((pos_q == '0) ? POS_LAST : pos_q - 1'b1);

  always_comb begin
    state_d    = state_q;
    updn_d     = updn_q;
    rem_d      = rem_q;
    hold_d     = hold_q;
    seen_low_d = seen_low_q;
    tmo_d      = tmo_q;
    pos_d      = pos_q;
    err_d      = err_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!PLL_LOCKED) begin
          pos_d = '0;
        end else if (accept) begin
          updn_d = req_updn;
          rem_d  = req_count;
          err_d  = 1'b0;
          if (req_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = S_ASSERT;
            hold_d     = '0;
            seen_low_d = 1'b0;
          end
        end
      end
      S_ASSERT: begin
        if (!phase_done) seen_low_d = 1'b1;
        if (hold_q == HOLD_LAST) begin
          state_d = S_WAIT_LOW;
          tmo_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_WAIT_LOW: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else if (seen_low_q || !phase_done) begin
          seen_low_d = 1'b1;
          state_d    = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else if (phase_done) begin
          pos_d = pos_next;
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        state_d    = S_ASSERT;
        hold_d     = '0;
        seen_low_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Lock loss overrides everything else decided above.
    if ((state_q != S_IDLE) && !PLL_LOCKED) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      done_d  = 1'b1;
      pos_d   = '0;
    end

    step_d = (state_d == S_ASSERT);
  end

  always_ff @(posedge CLK_IN or negedge RST_IN_N) begin
    if (!RST_IN_N) begin
      state_q    <= S_IDLE;
      updn_q     <= 1'b0;
      rem_q      <= '0;
      hold_q     <= '0;
      seen_low_q <= 1'b0;
      tmo_q      <= '0;
      pos_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      updn_q     <= updn_d;
      rem_q      <= rem_d;
      hold_q     <= hold_d;
      seen_low_q <= seen_low_d;
      tmo_q      <= tmo_d;
      pos_q      <= pos_d;
      err_q      <= err_d;
      done_q     <= done_d;
      step_q     <= step_d;
    end
  end

  assign phase_step  = step_q;
  assign phase_updn  = updn_q;
  assign busy        = (state_q != S_IDLE);
  assign done_pulse  = done_q;
  assign timeout_err = err_q;
  assign phase_pos   = pos_q;

endmodule

// File: tb/tb_ddr3_pll_phase_stepper.sv
// Bench for ddr3_pll_phase_stepper: behavioural PLL handshake model, vector table,
// randomized requests against an arithmetic phase model, and timeout/lock-loss sequences.
module tb_ddr3_pll_phase_stepper;

  localparam int unsigned REV  = 32;
  localparam int unsigned HOLD = 2;
  localparam int unsigned TMO  = 255;

  logic       clk;
  logic       rst_n;
  logic       locked;
  logic       req_valid;
  logic       req_ready;
  logic       req_updn;
  logic [7:0] req_count;
  logic       phase_step;
  logic       phase_updn;
  logic       phase_done;
  logic       busy;
  logic       done_pulse;
  logic       timeout_err;
  logic [4:0] phase_pos;

  ddr3_pll_phase_stepper #(
    .STEP_HOLD_CYCLES(HOLD),
    .DONE_TIMEOUT(TMO),
    .PHASE_STEPS_PER_REV(REV),
    .CNT_W(8)
  ) dut (
    .CLK_IN(clk),
    .RST_IN_N(rst_n),
    .PLL_LOCKED(locked),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_updn(req_updn),
    .req_count(req_count),
    .phase_step(phase_step),
    .phase_updn(phase_updn),
    .phase_done(phase_done),
    .busy(busy),
    .done_pulse(done_pulse),
    .timeout_err(timeout_err),
    .phase_pos(phase_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // PLL model: phase_done goes low pll_dly cycles after a phase_step rise, for pll_len cycles.
  int unsigned pll_dly   = 1;
  int unsigned pll_len   = 4;
  bit          pll_stuck = 1'b0;
  int unsigned pll_t     = 1000;
  bit          pll_prev  = 1'b0;

  always @(negedge clk) begin
    if (phase_step && !pll_prev) pll_t = 0;
    else if (pll_t < 1000) pll_t = pll_t + 1;
    pll_prev = phase_step;
    phase_done = pll_stuck ? 1'b1 : !((pll_t >= pll_dly) && (pll_t < pll_dly + pll_len));
  end

  // Output monitor: pulse counting, pulse width, direction stability, done pulses.
  bit exp_updn = 1'b0;
  int mon_pulses = 0, mon_len_err = 0, mon_updn_err = 0, mon_done = 0, cur_len = 0;
  bit step_prev = 1'b0;

  always @(negedge clk) begin
    if (phase_step && !step_prev) begin
      mon_pulses = mon_pulses + 1;
      cur_len = 1;
    end else if (phase_step) begin
      cur_len = cur_len + 1;
    end
    if (!phase_step && step_prev && cur_len != HOLD) mon_len_err = mon_len_err + 1;
    if (phase_step && (phase_updn != exp_updn)) mon_updn_err = mon_updn_err + 1;
    if (done_pulse) mon_done = mon_done + 1;
    step_prev = phase_step;
  end

  task automatic wait_ready(input string tag);
    int i;
    i = 0;
    while (!req_ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_ready"}, int'(req_ready), 1);
  endtask

  task automatic run_req(input string tag, input bit u, input int unsigned n,
                         input int unsigned exp_pos, input bit spam);
    int p0, l0, u0, d0, lat, spam_bad;
    wait_ready(tag);
    exp_updn = u;
    p0 = mon_pulses; l0 = mon_len_err; u0 = mon_updn_err; d0 = mon_done;
    req_valid = 1'b1;
    req_updn  = u;
    req_count = 8'(n);
    @(negedge clk);
    lat = 1;
    spam_bad = 0;
    if (spam) begin
      req_count = 8'd5;
      req_updn  = ~u;
    end else begin
      req_valid = 1'b0;
    end
    check({tag, "_err_clr"}, int'(timeout_err), 0);
    while (!done_pulse && lat < 5000) begin
      if (spam && req_ready) spam_bad++;
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    check({tag, "_done_seen"}, int'(lat < 5000), 1);
    if (n == 0) check({tag, "_zero_lat"}, lat, 1);
    if (spam) check({tag, "_ready_busy"}, spam_bad, 0);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_pulses"}, mon_pulses - p0, int'(n));
    check({tag, "_width"}, mon_len_err - l0, 0);
    check({tag, "_updn"}, mon_updn_err - u0, 0);
    check({tag, "_done_cnt"}, mon_done - d0, 1);
    check({tag, "_tmo_err"}, int'(timeout_err), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_pos"}, int'(phase_pos), int'(exp_pos));
  endtask

  typedef struct {
    bit          updn;
    int unsigned count;
    int unsigned exp_pos;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int p0, c, rises;
    bit pv;
    int unsigned pos_m, n;
    bit u;

    vecs[0] = '{1'b1, 3,  3};
    vecs[1] = '{1'b0, 4,  31};
    vecs[2] = '{1'b1, 1,  0};
    vecs[3] = '{1'b0, 1,  31};
    vecs[4] = '{1'b1, 1,  0};
    vecs[5] = '{1'b1, 0,  0};
    vecs[6] = '{1'b1, 33, 1};
    vecs[7] = '{1'b0, 2,  31};

    rst_n = 1'b0; locked = 1'b1; req_valid = 1'b0; req_updn = 1'b0; req_count = '0;
    repeat (3) @(negedge clk);
    check("rst_step", int'(phase_step), 0);
    check("rst_updn", int'(phase_updn), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done_pulse), 0);
    check("rst_err", int'(timeout_err), 0);
    check("rst_pos", int'(phase_pos), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", int'(req_ready), 1);
    check("idle_pos", int'(phase_pos), 0);

    foreach (vecs[i]) begin
      run_req($sformatf("vec%0d", i), vecs[i].updn, vecs[i].count, vecs[i].exp_pos, 1'b0);
    end

    // Timeout: PLL never acknowledges, position 31 must survive the abort.
    pll_stuck = 1'b1;
    wait_ready("tmo");
    exp_updn = 1'b0;
    p0 = mon_pulses;
    req_valid = 1'b1; req_updn = 1'b0; req_count = 8'd2;
    @(negedge clk);
    req_valid = 1'b0;
    c = 0;
    while (!phase_step && c < 10) begin @(negedge clk); c++; end
    check("tmo_step_hi", int'(phase_step), 1);
    c = 0;
    while (phase_step && c < 10) begin @(negedge clk); c++; end
    check("tmo_step_lo", int'(phase_step), 0);
    c = 0;
    while (!done_pulse && c < 1000) begin @(negedge clk); c++; end
    check("tmo_wait_cycles", c, int'(TMO));
    check("tmo_err_set", int'(timeout_err), 1);
    @(negedge clk);
    @(negedge clk);
    check("tmo_pulses", mon_pulses - p0, 1);
    check("tmo_err_sticky", int'(timeout_err), 1);
    check("tmo_pos", int'(phase_pos), 31);
    check("tmo_busy", int'(busy), 0);
    pll_stuck = 1'b0;
    run_req("after_tmo", 1'b1, 1, 0, 1'b0);
    run_req("pre_lock", 1'b1, 3, 3, 1'b0);

    // Lock loss during WAIT_HIGH of step 2 of 5.
    pll_dly = 1; pll_len = 4;
    wait_ready("lock");
    exp_updn = 1'b1;
    p0 = mon_pulses;
    req_valid = 1'b1; req_updn = 1'b1; req_count = 8'd5;
    @(negedge clk);
    req_valid = 1'b0;
    rises = 0; pv = 1'b0; c = 0;
    while (rises < 2 && c < 200) begin
      if (phase_step && !pv) rises++;
      pv = phase_step;
      if (rises < 2) begin @(negedge clk); c++; end
    end
    check("lock_rise2", rises, 2);
    repeat (3) @(negedge clk);
    check("lock_pos_before", int'(phase_pos), 4);
    check("lock_busy_before", int'(busy), 1);
    locked = 1'b0;
    @(negedge clk);
    check("lock_step", int'(phase_step), 0);
    check("lock_busy", int'(busy), 0);
    check("lock_pos", int'(phase_pos), 0);
    check("lock_err", int'(timeout_err), 1);
    check("lock_done", int'(done_pulse), 1);
    check("lock_ready", int'(req_ready), 0);
    repeat (3) @(negedge clk);
    check("lock_ready_hold", int'(req_ready), 0);
    locked = 1'b1;
    @(negedge clk);
    check("relock_ready", int'(req_ready), 1);
    repeat (10) @(negedge clk);
    check("relock_pulses", mon_pulses - p0, 2);

    // Lock loss while idle clears the position as well.
    run_req("pre_idle_lock", 1'b1, 7, 7, 1'b0);
    locked = 1'b0;
    @(negedge clk);
    check("idle_lock_pos", int'(phase_pos), 0);
    check("idle_lock_ready", int'(req_ready), 0);
    locked = 1'b1;
    @(negedge clk);

    run_req("spam", 1'b1, 2, 2, 1'b1);

    pos_m = 2;
    for (int k = 0; k < 20; k++) begin
      u = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 6);
      pll_dly = $urandom_range(0, 3);
      pll_len = $urandom_range(1, 6);
      pos_m = u ? (pos_m + n) % REV : (pos_m + REV - (n % REV)) % REV;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_req($sformatf("rnd%0d", k), u, n, pos_m, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
